// File: rtl/butterfly_array_pkg.sv
// Shared definitions for the butterfly datapath: mode encodings, default
// field parameters and the helper that derives the Barrett constant.
package butterfly_array_pkg;

  typedef enum logic [1:0] {
    BFLY_NTT    = 2'd0,
    BFLY_INTT   = 2'd1,
    BFLY_PWM    = 2'd2,
    BFLY_ADDSUB = 2'd3
  } bfly_mode_e;

  localparam int unsigned BFLY_W_DEFAULT = 12;
  localparam int unsigned BFLY_Q_DEFAULT = 3329;

  // Barrett multiplier floor(2^(2w) / q). With the shift fixed at 2w every
  // 2w-bit product reduces with at most one conditional subtraction.
  function automatic logic [63:0] barrett_mult(input int unsigned w, input int unsigned q);
    logic [63:0] num;
    num = 64'd1 << (2 * w);
    return num / 64'(q);
  endfunction

  localparam int unsigned BFLY_BARRETT_SHIFT = 2 * BFLY_W_DEFAULT;
  localparam logic [63:0] BFLY_BARRETT_M     = barrett_mult(BFLY_W_DEFAULT, BFLY_Q_DEFAULT);

endpackage

// File: rtl/butterfly_array_mod_mult.sv
// mod_mult: pipelined modular multiplier p = x*y mod Q.
// Stage 1 registers the raw 2W-bit product; Barrett reduction follows and the
// reduced value is carried through the remaining MULT_LAT-1 registers. Every
// register advances only when en is high so the unit stalls with its caller.
module mod_mult
  import butterfly_array_pkg::*;
#(
  parameter int unsigned W        = BFLY_W_DEFAULT,
  parameter int unsigned Q        = BFLY_Q_DEFAULT,
  parameter int unsigned MULT_LAT = 3
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] p
);

  localparam logic [63:0]    BM64 = barrett_mult(W, Q);
  localparam logic [2*W-1:0] BM   = BM64[2*W-1:0];
  localparam logic [2*W-1:0] QW   = (2*W)'(Q);

  // Barrett: the quotient estimate is short by at most one, so the remainder
  // lies in [0, 2Q) and a single conditional subtraction makes it canonical.
  function automatic logic [W-1:0] barrett_reduce(input logic [2*W-1:0] v);
    logic [4*W-1:0] qm;
    logic [2*W-1:0] q_est;
    logic [2*W-1:0] r;
    qm    = {{(2*W){1'b0}}, v} * {{(2*W){1'b0}}, BM};
    q_est = (2*W)'(qm >> (2 * W));
    r     = v - (q_est * QW);
    r     = (r >= QW) ? (r - QW) : r;
    return r[W-1:0];
  endfunction

  logic [2*W-1:0] prod_q;
  logic [2*W-1:0] prod_d;

  // Next product register value: new product when enabled, otherwise hold.
  always_comb begin
    if (en) begin
      prod_d = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    end else begin
      prod_d = prod_q;
    end
  end

  // Product register (first multiplier stage).
  always_ff @(posedge clk) begin
    prod_q <= prod_d;
  end

  if (MULT_LAT == 1) begin : g_lat1
    assign p = barrett_reduce(prod_q);
  end else begin : g_latn
    logic [W-1:0] red_q [MULT_LAT-1];
    logic [W-1:0] red_d [MULT_LAT-1];

    // Shift the reduced result along the remaining stages when enabled.
    always_comb begin
      if (en) begin
        red_d[0] = barrett_reduce(prod_q);
      end else begin
        red_d[0] = red_q[0];
      end
      for (int i = 1; i < int'(MULT_LAT) - 1; i++) begin
        if (en) begin
          red_d[i] = red_q[i-1];
        end else begin
          red_d[i] = red_q[i];
        end
      end
    end

    // Reduced-result delay registers.
    always_ff @(posedge clk) begin
      red_q <= red_d;
    end

    assign p = red_q[MULT_LAT-2];
  end

endmodule

// File: rtl/butterfly_array.sv
// butterfly_array: LANES parallel modular butterflies (NTT / INTT / PWM /
// ADDSUB) with a fixed MULT_LAT+2 cycle latency for every mode.
// Stages: input register, pre-add/sub register (INTT difference feeds the
// multiplier), MULT_LAT multiplier stages, final add/sub + output register.
// Optional macro BFLY_INTT_HALVE_EN folds a multiplication by 2^-1 mod Q into
// both INTT results without changing latency.
module butterfly_array
  import butterfly_array_pkg::*;
#(
  parameter int unsigned W        = BFLY_W_DEFAULT,
  parameter int unsigned Q        = BFLY_Q_DEFAULT,
  parameter int unsigned LANES    = 2,
  parameter int unsigned MULT_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  input  logic [LANES*W-1:0]   in_w,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_a,
  output logic [LANES*W-1:0]   out_b,
  output logic                 busy
);

  localparam int unsigned LW = LANES * W;
  localparam logic [W:0]  QX = (W+1)'(Q);

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    s = (s >= QX) ? (s - QX) : s;
    return s[W-1:0];
  endfunction

  // A borrow is repaired by adding Q; W+1-bit wraparound keeps this exact.
  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    d = (x < y) ? (d + QX) : d;
    return d[W-1:0];
  endfunction

`ifdef BFLY_INTT_HALVE_EN
  // x * 2^-1 mod Q: odd values get Q added first so the shift is exact.
  function automatic logic [W-1:0] mod_halve(input logic [W-1:0] x);
    logic [W:0] s;
    s = {1'b0, x};
    s = x[0] ? (s + QX) : s;
    return s[W:1];
  endfunction
`endif

  logic adv_s;
  logic accept_s;

  logic       v0_q, v0_d;
  bfly_mode_e mode0_q, mode0_d;
  logic [LW-1:0] a0_q, a0_d, b0_q, b0_d, w0_q, w0_d;

  logic       v1_q, v1_d;
  bfly_mode_e mode1_q, mode1_d;
  logic [LW-1:0] x1_q, x1_d, w1_q, w1_d, sa1_q, sa1_d, sb1_q, sb1_d;
  logic [LW-1:0] x1_s, sa1_s, sb1_s;

  logic [MULT_LAT-1:0] vm_q, vm_d;
  bfly_mode_e    modem_q [MULT_LAT];
  bfly_mode_e    modem_d [MULT_LAT];
  logic [LW-1:0] sam_q   [MULT_LAT];
  logic [LW-1:0] sam_d   [MULT_LAT];
  logic [LW-1:0] sbm_q   [MULT_LAT];
  logic [LW-1:0] sbm_d   [MULT_LAT];
  logic [LW-1:0] prod_s;

  logic          out_valid_q, out_valid_d;
  logic [LW-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic [LW-1:0] oa_s, ob_s;

  assign adv_s    = !out_valid_q || out_ready;
  assign in_ready = adv_s && !rst;
  assign accept_s = in_valid && in_ready;

  // Per-lane pre-stage: choose the multiplier operand and the side values
  // that bypass the multiplier, based on the beat's own mode.
  always_comb begin
    logic [W-1:0] la, lb, lsum, ldiff, lsum_i;
    x1_s  = '0;
    sa1_s = '0;
    sb1_s = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      la    = a0_q[i*W +: W];
      lb    = b0_q[i*W +: W];
      lsum  = mod_add(la, lb);
      ldiff = mod_sub(la, lb);
`ifdef BFLY_INTT_HALVE_EN
      lsum_i = mod_halve(lsum);
`else
      lsum_i = lsum;
`endif
      case (mode0_q)
        BFLY_INTT: begin
          x1_s[i*W +: W]  = ldiff;
          sa1_s[i*W +: W] = lsum_i;
          sb1_s[i*W +: W] = {W{1'b0}};
        end
        BFLY_ADDSUB: begin
          x1_s[i*W +: W]  = lb;
          sa1_s[i*W +: W] = lsum;
          sb1_s[i*W +: W] = ldiff;
        end
        BFLY_NTT, BFLY_PWM: begin
          x1_s[i*W +: W]  = lb;
          sa1_s[i*W +: W] = la;
          sb1_s[i*W +: W] = {W{1'b0}};
        end
        default: begin
          x1_s[i*W +: W]  = lb;
          sa1_s[i*W +: W] = la;
          sb1_s[i*W +: W] = {W{1'b0}};
        end
      endcase
    end
  end

  // Per-lane final stage: combine multiplier output with side values.
  always_comb begin
    logic [W-1:0] t, t_i, sa, sb;
    oa_s = '0;
    ob_s = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      t  = prod_s[i*W +: W];
      sa = sam_q[MULT_LAT-1][i*W +: W];
      sb = sbm_q[MULT_LAT-1][i*W +: W];
`ifdef BFLY_INTT_HALVE_EN
      t_i = mod_halve(t);
`else
      t_i = t;
`endif
      case (modem_q[MULT_LAT-1])
        BFLY_NTT: begin
          oa_s[i*W +: W] = mod_add(sa, t);
          ob_s[i*W +: W] = mod_sub(sa, t);
        end
        BFLY_INTT: begin
          oa_s[i*W +: W] = sa;
          ob_s[i*W +: W] = t_i;
        end
        BFLY_PWM: begin
          oa_s[i*W +: W] = sa;
          ob_s[i*W +: W] = t;
        end
        BFLY_ADDSUB: begin
          oa_s[i*W +: W] = sa;
          ob_s[i*W +: W] = sb;
        end
        default: begin
          oa_s[i*W +: W] = sa;
          ob_s[i*W +: W] = sb;
        end
      endcase
    end
  end

  // Next-state for every pipeline stage: advance on adv, otherwise hold.
  always_comb begin
    if (adv_s) begin
      v0_d        = accept_s;
      mode0_d     = bfly_mode_e'(in_mode);
      a0_d        = in_a;
      b0_d        = in_b;
      w0_d        = in_w;
      v1_d        = v0_q;
      mode1_d     = mode0_q;
      x1_d        = x1_s;
      w1_d        = w0_q;
      sa1_d       = sa1_s;
      sb1_d       = sb1_s;
      vm_d[0]     = v1_q;
      modem_d[0]  = mode1_q;
      sam_d[0]    = sa1_q;
      sbm_d[0]    = sb1_q;
      for (int i = 1; i < int'(MULT_LAT); i++) begin
        vm_d[i]    = vm_q[i-1];
        modem_d[i] = modem_q[i-1];
        sam_d[i]   = sam_q[i-1];
        sbm_d[i]   = sbm_q[i-1];
      end
      out_valid_d = vm_q[MULT_LAT-1];
      out_a_d     = oa_s;
      out_b_d     = ob_s;
    end else begin
      v0_d        = v0_q;
      mode0_d     = mode0_q;
      a0_d        = a0_q;
      b0_d        = b0_q;
      w0_d        = w0_q;
      v1_d        = v1_q;
      mode1_d     = mode1_q;
      x1_d        = x1_q;
      w1_d        = w1_q;
      sa1_d       = sa1_q;
      sb1_d       = sb1_q;
      vm_d        = vm_q;
      for (int i = 0; i < int'(MULT_LAT); i++) begin
        modem_d[i] = modem_q[i];
        sam_d[i]   = sam_q[i];
        sbm_d[i]   = sbm_q[i];
      end
      out_valid_d = out_valid_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
    end
  end

  // Valid bits and output registers; reset discards every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      vm_q        <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
    end else begin
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      vm_q        <= vm_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
    end
  end

  // Datapath and mode-tag registers; their contents are qualified by valid.
  always_ff @(posedge clk) begin
    mode0_q <= mode0_d;
    a0_q    <= a0_d;
    b0_q    <= b0_d;
    w0_q    <= w0_d;
    mode1_q <= mode1_d;
    x1_q    <= x1_d;
    w1_q    <= w1_d;
    sa1_q   <= sa1_d;
    sb1_q   <= sb1_d;
    modem_q <= modem_d;
    sam_q   <= sam_d;
    sbm_q   <= sbm_d;
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    mod_mult #(
      .W        (W),
      .Q        (Q),
      .MULT_LAT (MULT_LAT)
    ) u_mod_mult (
      .clk (clk),
      .en  (adv_s),
      .x   (x1_q[g*W +: W]),
      .y   (w1_q[g*W +: W]),
      .p   (prod_s[g*W +: W])
    );
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign busy      = v0_q | v1_q | (|vm_q) | out_valid_q;

endmodule

// File: tb/tb_butterfly_array.sv
// Self-checking bench for butterfly_array: directed cases, mixed modes,
// backpressure, reset and a long random run against a modular-arithmetic
// reference model. Honours BFLY_INTT_HALVE_EN when defined.
module tb_butterfly_array;

  localparam int W        = 12;
  localparam int Q        = 3329;
  localparam int LANES    = 2;
  localparam int MULT_LAT = 3;
  localparam int L        = MULT_LAT + 2;
  localparam int LW       = LANES * W;
  localparam longint INV2 = (Q + 1) / 2;

  typedef struct {
    logic [LW-1:0] ea;
    logic [LW-1:0] eb;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [LW-1:0] in_a, in_b, in_w;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_a, out_b;
  logic          busy;

  butterfly_array #(.W(W), .Q(Q), .LANES(LANES), .MULT_LAT(MULT_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_w      (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic          drv_rst, drv_valid, drv_ready;
  logic [1:0]    drv_mode;
  logic [LW-1:0] drv_a, drv_b, drv_w;

  logic          last_valid, last_busy, last_in_ready, last_acc, last_pop;
  logic [LW-1:0] last_a, last_b;

  exp_t exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: straight modular arithmetic on each lane.
  function automatic exp_t model(input logic [1:0] m, input logic [LW-1:0] va,
                                 input logic [LW-1:0] vb, input logic [LW-1:0] vw);
    exp_t r;
    longint a, b, w, t, ea, eb;
    for (int i = 0; i < LANES; i++) begin
      a = longint'(va[i*W +: W]);
      b = longint'(vb[i*W +: W]);
      w = longint'(vw[i*W +: W]);
      case (m)
        2'd0: begin t = (b * w) % Q; ea = (a + t) % Q; eb = (a - t + Q) % Q; end
        2'd1: begin ea = (a + b) % Q; eb = (((a - b + Q) % Q) * w) % Q; end
        2'd2: begin ea = a; eb = (b * w) % Q; end
        default: begin ea = (a + b) % Q; eb = (a - b + Q) % Q; end
      endcase
`ifdef BFLY_INTT_HALVE_EN
      if (m == 2'd1) begin
        ea = (ea * INV2) % Q;
        eb = (eb * INV2) % Q;
      end
`endif
      r.ea[i*W +: W] = W'(ea);
      r.eb[i*W +: W] = W'(eb);
    end
    return r;
  endfunction

  // One clock: drive at the falling edge, observe, update the scoreboard.
  task automatic step();
    @(negedge clk);
    rst       = drv_rst;
    in_valid  = drv_valid;
    in_mode   = drv_mode;
    in_a      = drv_a;
    in_b      = drv_b;
    in_w      = drv_w;
    out_ready = drv_ready;
    #1;
    last_valid    = out_valid;
    last_busy     = busy;
    last_in_ready = in_ready;
    last_a        = out_a;
    last_b        = out_b;
    last_acc      = in_valid && in_ready;
    last_pop      = out_valid && out_ready;
    check_eq("in_ready_rule", 64'(in_ready), 64'((!out_valid || out_ready) && !rst));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("stale_beat", 64'(out_valid), 64'd0);
      end else begin
        check_eq("sb_out_a", 64'(out_a), 64'(exp_q[0].ea));
        check_eq("sb_out_b", 64'(out_b), 64'(exp_q[0].eb));
      end
    end
    if (last_pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (last_acc) exp_q.push_back(model(in_mode, in_a, in_b, in_w));
    if (rst) exp_q.delete();
  endtask

  task automatic set_beat(input logic [1:0] m, input int a, input int b, input int w);
    drv_mode = m;
    drv_a    = {LANES{W'(a)}};
    drv_b    = {LANES{W'(b)}};
    drv_w    = {LANES{W'(w)}};
  endtask

  task automatic set_random_beat();
    drv_mode = 2'($urandom_range(3, 0));
    for (int i = 0; i < LANES; i++) begin
      drv_a[i*W +: W] = W'($urandom_range(Q - 1, 0));
      drv_b[i*W +: W] = W'($urandom_range(Q - 1, 0));
      drv_w[i*W +: W] = W'($urandom_range(Q - 1, 0));
    end
  endtask

  task automatic drain(input int max_steps);
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    for (int i = 0; i < max_steps && exp_q.size() > 0; i++) step();
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic directed(input string tag, input logic [1:0] m, input int a, input int b,
                          input int w, input int ea, input int eb);
    int lat;
    logic [W-1:0] ga, gb;
    lat = -1;
    ga  = '0;
    gb  = '0;
    drv_ready = 1'b1;
    drv_valid = 1'b1;
    set_beat(m, a, b, w);
    step();
    check_eq({tag, "_accept"}, 64'(last_acc), 64'd1);
    drv_valid = 1'b0;
    for (int j = 1; j <= 20 && lat < 0; j++) begin
      step();
      if (last_valid) begin
        lat = j - 1;
        ga  = last_a[W-1:0];
        gb  = last_b[W-1:0];
      end
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'(L));
    check_eq({tag, "_out_a"}, 64'(ga), 64'(ea));
    check_eq({tag, "_out_b"}, 64'(gb), 64'(eb));
  endtask

  initial begin
    int ma[4], mb[4], mw[4], ea[4], eb[4];
    int pop_step[$];
    logic [W-1:0] pop_a[$];
    logic [W-1:0] pop_b[$];
    int acc_cnt, pop_cnt, beats;

    drv_rst = 1'b1; drv_valid = 1'b1; drv_ready = 1'b1;
    set_beat(2'd0, 1, 2, 3);
    step();
    step();
    check_eq("rst_in_ready", 64'(last_in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(last_valid), 64'd0);
    check_eq("rst_busy", 64'(last_busy), 64'd0);
    check_eq("rst_out_a", 64'(last_a), 64'd0);
    check_eq("rst_out_b", 64'(last_b), 64'd0);
    drv_rst = 1'b0; drv_valid = 1'b0;
    step();

    directed("ntt", 2'd0, 1, 2, 17, 35, 3296);
`ifdef BFLY_INTT_HALVE_EN
    directed("intt", 2'd1, 5, 3, 2, 4, 2);
`else
    directed("intt", 2'd1, 5, 3, 2, 8, 4);
`endif
    directed("pwm", 2'd2, 100, 33, 101, 100, 4);
    directed("addsub", 2'd3, 3328, 1, 0, 0, 3327);

    // Back-to-back mixed modes.
    ma = '{1, 5, 100, 3328}; mb = '{2, 3, 33, 1}; mw = '{17, 2, 101, 7};
`ifdef BFLY_INTT_HALVE_EN
    ea = '{35, 4, 100, 0}; eb = '{3296, 2, 4, 3327};
`else
    ea = '{35, 8, 100, 0}; eb = '{3296, 4, 4, 3327};
`endif
    drv_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drv_valid = 1'b1;
      set_beat(2'(k), ma[k], mb[k], mw[k]);
      step();
      if (last_pop) begin pop_step.push_back(k); pop_a.push_back(last_a[W-1:0]); pop_b.push_back(last_b[W-1:0]); end
    end
    drv_valid = 1'b0;
    for (int j = 4; j < 24; j++) begin
      step();
      if (last_pop) begin pop_step.push_back(j); pop_a.push_back(last_a[W-1:0]); pop_b.push_back(last_b[W-1:0]); end
    end
    check_eq("b2b_count", 64'(pop_step.size()), 64'd4);
    for (int k = 0; k < 4 && k < pop_step.size(); k++) begin
      check_eq("b2b_consecutive", 64'(pop_step[k] - pop_step[0]), 64'(k));
      check_eq("b2b_out_a", 64'(pop_a[k]), 64'(ea[k]));
      check_eq("b2b_out_b", 64'(pop_b[k]), 64'(eb[k]));
    end

    // Backpressure: sink stalled for 10 cycles with continuous input.
    acc_cnt = 0;
    drv_ready = 1'b0;
    for (int j = 0; j < 10; j++) begin
      drv_valid = 1'b1;
      set_random_beat();
      step();
      if (last_acc) acc_cnt++;
    end
    check_eq("bp_accepted", 64'(acc_cnt), 64'(L + 1));
    check_eq("bp_in_ready_low", 64'(last_in_ready), 64'd0);
    pop_cnt = 0;
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step();
      if (last_pop) pop_cnt++;
    end
    check_eq("bp_popped", 64'(pop_cnt), 64'(L + 1));
    check_eq("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with three beats in flight.
    for (int j = 0; j < 3; j++) begin
      drv_valid = 1'b1;
      set_random_beat();
      step();
    end
    drv_rst = 1'b1;
    step();
    check_eq("rst_mid_no_accept", 64'(last_acc), 64'd0);
    drv_rst = 1'b0;
    drv_valid = 1'b0;
    step();
    check_eq("rst_mid_out_valid", 64'(last_valid), 64'd0);
    check_eq("rst_mid_busy", 64'(last_busy), 64'd0);
    check_eq("rst_mid_out_a", 64'(last_a), 64'd0);
    check_eq("rst_mid_out_b", 64'(last_b), 64'd0);
    pop_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      step();
      if (last_valid) pop_cnt++;
    end
    check_eq("rst_mid_no_stale", 64'(pop_cnt), 64'd0);

    // Long random run with random backpressure and rare resets.
    beats = 0;
    for (int j = 0; j < 40000 && beats < 10000; j++) begin
      drv_valid = ($urandom_range(3, 0) != 0);
      drv_ready = ($urandom_range(3, 0) != 0);
      drv_rst   = ($urandom_range(999, 0) == 0);
      set_random_beat();
      step();
      if (last_acc) beats++;
    end
    drv_rst = 1'b0;
    check_eq("rand_beats", 64'(beats), 64'd10000);
    drain(60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
